// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - multi-cycle fetch/exec/writeback sequencer with PC, retire count and halt
module inst_sequencer #(
    parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_imem_req_valid,
    input  logic        io_imem_req_ready,
    output logic [63:0] io_imem_req_addr,
    input  logic        io_imem_resp_valid,
    input  logic [31:0] io_imem_resp_data,
    output logic [31:0] io_inst,
    input  logic [63:0] io_exu_result,
    output logic        io_rf_wen,
    output logic [4:0]  io_rf_waddr,
    output logic [63:0] io_rf_wdata,
    output logic [63:0] io_pc,
    output logic        io_halt,
    output logic        io_illegal,
    output logic [63:0] io_retire_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_RESP,
        EXEC,
        WB,
        HALT
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [63:0] pc;
    logic [63:0] wdata;
    logic [63:0] retire_count;
    logic [31:0] inst;
    logic        halt;
    logic        illegal;
    logic        is_addi;
    logic        is_ebreak;

    assign is_addi   = (inst[6:0] == 7'b0010011) && (inst[14:12] == 3'b000);
    assign is_ebreak = (inst == 32'h0010_0073);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      next_state = FETCH;
            FETCH:     if (io_imem_req_ready) next_state = WAIT_RESP;
            WAIT_RESP: if (io_imem_resp_valid) next_state = EXEC;
            EXEC:      next_state = is_addi ? WB : HALT;
            WB:        next_state = FETCH;
            HALT:      next_state = HALT;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc           <= PC_RESET;
            inst         <= 32'h0;
            wdata        <= 64'h0;
            retire_count <= 64'h0;
            halt         <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            case (state)
                WAIT_RESP: begin
                    if (io_imem_resp_valid) inst <= io_imem_resp_data;
                end
                EXEC: begin
                    if (is_addi) begin
                        wdata <= io_exu_result;
                    end else begin
                        halt    <= 1'b1;
                        illegal <= !is_ebreak;
                    end
                end
                WB: begin
                    // rd=x0 still retires; only the write strobe is suppressed
                    pc           <= pc + 64'd4;
                    retire_count <= retire_count + 64'd1;
                end
                default: ;
            endcase
        end
    end

    assign io_imem_req_valid = (state == FETCH);
    assign io_imem_req_addr  = pc;
    assign io_inst           = inst;
    assign io_rf_wen         = (state == WB) && (inst[11:7] != 5'd0);
    assign io_rf_waddr       = inst[11:7];
    assign io_rf_wdata       = wdata;
    assign io_pc             = pc;
    assign io_halt           = halt;
    assign io_illegal        = illegal;
    assign io_retire_count   = retire_count;

endmodule

// File: doc/inst_sequencer.md
# inst_sequencer

Multi-cycle control sequencer for the single-issue NPC core. Owns the PC, drives instruction fetch over a valid/ready request channel, latches the instruction for the decode/execute datapath (IDU → EXU), captures the execute result, and issues one register-file write per retired instruction. It stops the core on `ebreak` or on any unsupported encoding.

## Interface
- `PC_RESET`, default 64'h8000_0000: PC value loaded on reset.
- `clock`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low; low at a rising edge resets the block.
- `io_imem_req_valid`  out  1  fetch request valid.
- `io_imem_req_ready`  in  1  memory accepts the request.
- `io_imem_req_addr`  out  64  fetch address; always equals `io_pc`.
- `io_imem_resp_valid`  in  1  fetch data valid.
- `io_imem_resp_data`  in  32  fetched instruction.
- `io_inst`  out  32  latched instruction, fed to decode.
- `io_exu_result`  in  64  combinational execute result for `io_inst`.
- `io_rf_wen`  out  1  register-file write strobe, one-cycle pulse.
- `io_rf_waddr`  out  5  destination register, `io_inst[11:7]`.
- `io_rf_wdata`  out  64  registered execute result.
- `io_pc`  out  64  current PC.
- `io_halt`  out  1  sticky; core stopped.
- `io_illegal`  out  1  sticky; stop caused by an unsupported instruction.
- `io_retire_count`  out  64  number of instructions written back since reset.

## Operation
- States: IDLE, FETCH, WAIT_RESP, EXEC, WB, HALT.
- IDLE: entered on reset. Moves to FETCH on the first edge with `reset` high.
- FETCH: `io_imem_req_valid`=1. Moves to WAIT_RESP on an edge where `io_imem_req_ready`=1.
- WAIT_RESP: on `io_imem_resp_valid`=1, latch `io_imem_resp_data` into `io_inst`, then go to EXEC.
- EXEC: decode the latched `io_inst`.
  - Supported op (opcode 7'b0010011, funct3 3'b000, i.e. addi): latch `io_exu_result` into the wdata register and go to WB.
  - Exactly 32'h0010_0073 (ebreak): go to HALT with `io_halt`=1 and `io_illegal`=0.
  - Anything else: go to HALT with `io_halt`=1 and `io_illegal`=1.
- WB:
  - `io_rf_wen`=1 only if `io_rf_waddr` != 0. An rd=x0 write is suppressed, but the instruction still retires.
  - `pc <= pc + 4`, wrapping modulo 2^64.
  - `retire_count <= retire_count + 1`, wrapping modulo 2^64.
  - Next state is FETCH.
- HALT: absorbing. Only reset leaves it. PC, `io_inst` and `retire_count` are frozen, and no requests are issued.
- ebreak and illegal instructions do not retire and do not advance the PC.
- `io_imem_resp_valid` is ignored in every state except WAIT_RESP. `io_imem_req_ready` is ignored outside FETCH.

## Timing
- Reset values:
  - State IDLE.
  - `io_pc`=`PC_RESET`.
  - `io_inst`=0, `io_rf_wdata`=0, `io_retire_count`=0.
  - `io_imem_req_valid`=0, `io_rf_wen`=0, `io_halt`=0, `io_illegal`=0.
- All outputs are registered or decoded from the registered state. There are no combinational input-to-output paths.
- Request rules:
  - `io_imem_req_valid` stays high until the handshake completes.
  - `io_imem_req_addr` is stable while valid is high.
  - Valid never drops without ready.
- A response on the same edge as the request handshake is not accepted. The earliest accepted response is on the following edge.
- Minimum cycles per instruction is 4: FETCH, WAIT_RESP, EXEC, WB. This requires ready=1 in FETCH and resp_valid=1 on the first WAIT_RESP cycle.
- The first request is valid in the second cycle after reset is released.
- `io_exu_result` must be valid in the EXEC cycle. The datapath is combinational from `io_inst`.
- `io_rf_wen` is high for exactly one cycle per retired instruction with rd≠0.
  - In that same cycle, `io_rf_waddr`/`io_rf_wdata` are valid and `io_pc` still shows the old PC.
  - The new PC is visible in the next cycle, in FETCH.
- Reset mid-operation (any state, including an outstanding fetch): the block returns to IDLE next cycle with the reset values above. The memory shares the same reset, so no stale response is expected.

## Test plan
- Reset release with `PC_RESET` default → `io_pc`=0x8000_0000. `io_imem_req_valid` is 0 in cycle 1 and 1 in cycle 2. All other outputs are 0.
- addi x1,x0,5 (0x0050_0093), ready=1, response next cycle, `io_exu_result`=5 → exactly 4 cycles later, `io_rf_wen` pulses with waddr=1 and wdata=5. Then `io_pc`=0x8000_0004 and `io_retire_count`=1.
- Backpressure: ready held low 3 cycles in FETCH → req_valid stays 1 and addr is unchanged. A `resp_valid` pulse during FETCH is ignored and `io_inst` is unchanged.
- addi x0,x0,1 (0x0010_0013) → no `io_rf_wen`. `io_pc` advances by 4 and `io_retire_count` increments.
- ebreak 0x0010_0073 → `io_halt`=1 and `io_illegal`=0. Then inst 0x0000_0000 after reset → `io_halt`=1 and `io_illegal`=1. In both cases the PC is unchanged, no further req_valid is issued for 20 cycles, and the retire count is unchanged.
- Reset pulled low during WAIT_RESP after 3 retired instructions → next cycle state is IDLE, `io_pc`=0x8000_0000, `io_retire_count`=0. Normal fetch resumes after release.
